// File: rtl/ram_access_port.sv
// Single-port byte RAM with a four-way requester mux (CNN, file loader, decompressor, host)
// and a one-cycle access engine that reports read/write completion with done pulses.
module ram_access_port #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              load,
  input  logic              cnn,
  input  logic              ext_wr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] dec_wdata,
  input  logic              dec_we,
  input  logic [ADDR_W-1:0] file_addr,
  input  logic [DATA_W-1:0] file_wdata,
  input  logic              file_we,
  input  logic [ADDR_W-1:0] cnn_addr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              done_rd,
  output logic              done_wr
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done_rd;
  logic              r_done_wr;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              w_rd;

  // CNN wins over the loader phase; in the loader phase ext_wr picks file vs decompressor.
  always_comb begin
    w_addr  = host_addr;
    w_wdata = host_wdata;
    w_we    = ext_wr;
    if (cnn) begin
      w_addr  = cnn_addr;
      w_wdata = '0;
      w_we    = 1'b0;
    end else if (load && ext_wr) begin
      w_addr  = file_addr;
      w_wdata = file_wdata;
      w_we    = file_we;
    end else if (load) begin
      w_addr  = dec_addr;
      w_wdata = dec_wdata;
      w_we    = dec_we;
    end
  end

  assign w_rd = rd_req && !w_we;

  // RAM is never cleared; a write presented while reset is held is discarded.
  always_ff @(posedge clk) begin
    if (!RST && w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_rd_data <= '0;
      r_done_rd <= 1'b0;
      r_done_wr <= 1'b0;
    end else begin
      r_done_wr <= w_we;
      r_done_rd <= w_rd;
      if (w_rd) begin
        r_rd_data <= r_mem[w_addr];
      end
    end
  end

  assign rd_data = r_rd_data;
  assign done_rd = r_done_rd;
  assign done_wr = r_done_wr;

endmodule

// File: tb/tb_ram_access_port.sv
// Scoreboard bench for ram_access_port: a reference model predicts each cycle's outputs,
// the prediction is queued at drive time and popped after the clock edge.
module tb_ram_access_port;

  logic        clk;
  logic        RST;
  logic        load, cnn, ext_wr;
  logic [15:0] dec_addr, file_addr, cnn_addr, host_addr;
  logic [7:0]  dec_wdata, file_wdata, host_wdata;
  logic        dec_we, file_we, rd_req;
  logic [7:0]  rd_data;
  logic        done_rd, done_wr;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] mdl_mem [int];
  logic [7:0] mdl_rd;
  int         n_checks;
  int         n_errors;

  ram_access_port #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .RST(RST), .load(load), .cnn(cnn), .ext_wr(ext_wr),
    .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_we(dec_we),
    .file_addr(file_addr), .file_wdata(file_wdata), .file_we(file_we),
    .cnn_addr(cnn_addr), .host_addr(host_addr), .host_wdata(host_wdata),
    .rd_req(rd_req), .rd_data(rd_data), .done_rd(done_rd), .done_wr(done_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    load = 0; cnn = 0; ext_wr = 0; rd_req = 0;
    dec_we = 0; file_we = 0;
    dec_addr = 0; file_addr = 0; cnn_addr = 0; host_addr = 0;
    dec_wdata = 0; file_wdata = 0; host_wdata = 0;
  endtask

  // Predict the edge outcome from the current inputs, queue it, clock, then compare.
  task automatic step(input string tag);
    logic [15:0] a;
    logic [7:0]  wd;
    logic        we;
    exp_t        e;
    exp_t        got;
    if (cnn) begin
      a = cnn_addr; wd = 8'h00; we = 1'b0;
    end else if (load && ext_wr) begin
      a = file_addr; wd = file_wdata; we = file_we;
    end else if (load) begin
      a = dec_addr; wd = dec_wdata; we = dec_we;
    end else begin
      a = host_addr; wd = host_wdata; we = ext_wr;
    end
    if (we) begin
      mdl_mem[int'(a)] = wd;
      e = '{wr: 1'b1, rd: 1'b0, data: mdl_rd};
    end else if (rd_req) begin
      mdl_rd = mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : 8'h00;
      e = '{wr: 1'b0, rd: 1'b1, data: mdl_rd};
    end else begin
      e = '{wr: 1'b0, rd: 1'b0, data: mdl_rd};
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".done_wr"}, 32'(done_wr), 32'(got.wr));
    chk({tag, ".done_rd"}, 32'(done_rd), 32'(got.rd));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(got.data));
  endtask

  task automatic host_rd(input logic [15:0] a, input string tag);
    set_idle();
    host_addr = a; rd_req = 1;
    step(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mdl_rd   = 8'h00;

    // Reset with every request active
    set_idle();
    RST = 1;
    ext_wr = 1; rd_req = 1; host_addr = 16'h0010; host_wdata = 8'hEE;
    dec_we = 1; file_we = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rd_data", 32'(rd_data), 32'h0);
    chk("rst.done_rd", 32'(done_rd), 32'h0);
    chk("rst.done_wr", 32'(done_wr), 32'h0);
    @(negedge clk);
    RST = 0;
    set_idle();

    // Host write then read, read held two cycles
    ext_wr = 1; host_addr = 16'h0010; host_wdata = 8'hA5;
    step("host_wr");
    set_idle(); host_addr = 16'h0010; rd_req = 1;
    step("host_rd0");
    step("host_rd1");
    set_idle();
    step("idle_hold");

    // Decompressor path; host and file inputs present but ignored
    set_idle();
    load = 1; dec_we = 1; dec_addr = 16'h0100; dec_wdata = 8'h3C;
    host_wdata = 8'hFF; host_addr = 16'h0100;
    file_we = 1; file_addr = 16'h0100; file_wdata = 8'h99;
    step("dec_wr");
    host_rd(16'h0100, "dec_rb");

    // File path at the top address
    set_idle();
    load = 1; ext_wr = 1; file_we = 1; file_addr = 16'hFFFF; file_wdata = 8'h7E;
    step("file_wr");
    host_rd(16'hFFFF, "file_rb");

    // CNN override blocks the decompressor write
    set_idle();
    cnn = 1; load = 1; dec_we = 1; dec_addr = 16'h0100; dec_wdata = 8'h00;
    rd_req = 1; cnn_addr = 16'h0100;
    step("cnn_rd");
    host_rd(16'h0100, "cnn_nowr");

    // Reads through the decompressor and file address paths
    set_idle();
    load = 1; dec_addr = 16'hFFFF; rd_req = 1;
    step("dec_rd");
    set_idle();
    load = 1; ext_wr = 1; file_addr = 16'h0010; rd_req = 1;
    step("file_rd");

    // Simultaneous write and read
    set_idle();
    ext_wr = 1; rd_req = 1; host_addr = 16'h0020; host_wdata = 8'h55;
    step("conflict");
    host_rd(16'h0020, "conflict_rb");

    // Preload a small window, then random traffic across all sources
    for (int i = 0; i < 16; i++) begin
      set_idle();
      ext_wr = 1; host_addr = 16'(i); host_wdata = 8'($urandom_range(0, 255));
      step("preload");
    end
    for (int i = 0; i < 40; i++) begin
      set_idle();
      cnn = 1'($urandom_range(0, 3) == 0);
      load = 1'($urandom_range(0, 1));
      ext_wr = 1'($urandom_range(0, 1));
      dec_we = 1'($urandom_range(0, 1));
      file_we = 1'($urandom_range(0, 1));
      rd_req = 1'($urandom_range(0, 1));
      dec_addr = 16'($urandom_range(0, 15));
      file_addr = 16'($urandom_range(0, 15));
      cnn_addr = 16'($urandom_range(0, 15));
      host_addr = 16'($urandom_range(0, 15));
      dec_wdata = 8'($urandom_range(0, 255));
      file_wdata = 8'($urandom_range(0, 255));
      host_wdata = 8'($urandom_range(0, 255));
      step("rand");
    end

    // Mid-run async reset: outputs clear at once and the pending write is lost
    set_idle();
    ext_wr = 1; host_addr = 16'h0030; host_wdata = 8'h11;
    step("pre_rst_wr");
    set_idle();
    ext_wr = 1; rd_req = 1; host_addr = 16'h0030; host_wdata = 8'hEE;
    #1;
    RST = 1;
    #1;
    chk("arst.done_wr", 32'(done_wr), 32'h0);
    chk("arst.rd_data", 32'(rd_data), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold.done_wr", 32'(done_wr), 32'h0);
    chk("arst_hold.done_rd", 32'(done_rd), 32'h0);
    @(negedge clk);
    RST = 0;
    mdl_rd = 8'h00;
    host_rd(16'h0030, "post_rst_rb");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
